// File: rtl/snake_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : snake_run_ctrl
// Brief  : Snake display sequencer: pattern counter, direction, run index,
//          start/pause/resume control and done status.
// Rev    : 1.0 - initial release
// ============================================================================
module snake_run_ctrl #(
    parameter int CNT_LENGTH = 20,
    parameter int MAX_RUNS   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       mode,
    input  logic       dir_in,
    output logic [4:0] ptn_cnt,
    output logic       updn,
    output logic [3:0] run_cnt,
    output logic       run_end,
    output logic       done,
    output logic       busy,
    output logic [1:0] state
);

    localparam logic [4:0] c_LAST = 5'(CNT_LENGTH - 1);
    localparam logic [3:0] c_MAXR = 4'(MAX_RUNS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] ptn_q, ptn_d;
    logic       updn_q, updn_d;
    logic [3:0] run_q, run_d;
    logic       run_end_q, run_end_d;
    logic       done_q, busy_q;
    logic       w_at_end;

    assign w_at_end = updn_q ? (ptn_q == c_LAST) : (ptn_q == 5'd0);

    always_comb begin
        state_d   = state_q;
        ptn_d     = ptn_q;
        updn_d    = updn_q;
        run_d     = run_q;
        run_end_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    updn_d  = dir_in;
                    ptn_d   = dir_in ? 5'd0 : c_LAST;
                    run_d   = 4'd1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pause) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    if (!w_at_end) begin
                        ptn_d = updn_q ? ptn_q + 5'd1 : ptn_q - 5'd1;
                    end else if (run_q == c_MAXR) begin
                        run_end_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        run_end_d = 1'b1;
                        run_d     = run_q + 4'd1;
                        // Ping-pong keeps the endpoint for one tick and turns around.
                        if (mode) begin
                            updn_d = ~updn_q;
                        end else begin
                            ptn_d = updn_q ? 5'd0 : c_LAST;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (start && !pause) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptn_q     <= 5'd0;
            updn_q    <= 1'b1;
            run_q     <= 4'd0;
            run_end_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptn_q     <= ptn_d;
            updn_q    <= updn_d;
            run_q     <= run_d;
            run_end_q <= run_end_d;
            done_q    <= (state_d == S_DONE);
            busy_q    <= (state_d == S_RUN) || (state_d == S_PAUSE);
        end
    end

    assign ptn_cnt = ptn_q;
    assign updn    = updn_q;
    assign run_cnt = run_q;
    assign run_end = run_end_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_snake_run_ctrl
// Brief  : Bench for snake_run_ctrl using three parameterisations in parallel.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_snake_run_ctrl;

    localparam int c_N = 3;

    logic clk = 1'b0;
    logic rst, tick, start, pause, mode, dir_in;

    logic [4:0] ptn  [c_N];
    logic       updn [c_N];
    logic [3:0] run  [c_N];
    logic       rend [c_N];
    logic       dn   [c_N];
    logic       bsy  [c_N];
    logic [1:0] st   [c_N];

    int n_assert = 0;
    int n_fail   = 0;

    // Model: position is derived from the tick index within the current run.
    int len   [c_N] = '{20, 4, 2};
    int maxr  [c_N] = '{9, 3, 1};
    int m_st  [c_N];
    int m_t   [c_N];
    int m_up  [c_N];
    int m_run [c_N];
    int m_end [c_N];

    always #5 clk = ~clk;

    snake_run_ctrl #(.CNT_LENGTH(20), .MAX_RUNS(9)) u_dut_a (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .mode(mode), .dir_in(dir_in), .ptn_cnt(ptn[0]), .updn(updn[0]),
        .run_cnt(run[0]), .run_end(rend[0]), .done(dn[0]), .busy(bsy[0]),
        .state(st[0]));

    snake_run_ctrl #(.CNT_LENGTH(4), .MAX_RUNS(3)) u_dut_b (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .mode(mode), .dir_in(dir_in), .ptn_cnt(ptn[1]), .updn(updn[1]),
        .run_cnt(run[1]), .run_end(rend[1]), .done(dn[1]), .busy(bsy[1]),
        .state(st[1]));

    snake_run_ctrl #(.CNT_LENGTH(2), .MAX_RUNS(1)) u_dut_c (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause),
        .mode(mode), .dir_in(dir_in), .ptn_cnt(ptn[2]), .updn(updn[2]),
        .run_cnt(run[2]), .run_end(rend[2]), .done(dn[2]), .busy(bsy[2]),
        .state(st[2]));

    function automatic int exp_pos(int i);
        return (m_up[i] != 0) ? m_t[i] : (len[i] - 1 - m_t[i]);
    endfunction

    task automatic model_step(int i);
        if (rst) begin
            m_st[i] = 0; m_t[i] = 0; m_up[i] = 1; m_run[i] = 0; m_end[i] = 0;
            return;
        end
        m_end[i] = 0;
        case (m_st[i])
            0, 3: if (start) begin
                m_up[i] = dir_in; m_t[i] = 0; m_run[i] = 1; m_st[i] = 1;
            end
            1: if (pause) m_st[i] = 2;
               else if (tick) begin
                   if (m_t[i] < len[i] - 1) m_t[i]++;
                   else begin
                       m_end[i] = 1;
                       if (m_run[i] == maxr[i]) m_st[i] = 3;
                       else begin
                           m_run[i]++;
                           m_t[i] = 0;
                           if (mode) m_up[i] = 1 - m_up[i];
                       end
                   end
               end
            2: if (start && !pause) m_st[i] = 1;
            default: ;
        endcase
    endtask

    task automatic check_all();
        logic [14:0] obs, exp;
        for (int i = 0; i < c_N; i++) begin
            obs = {st[i], ptn[i], updn[i], run[i], rend[i], dn[i], bsy[i]};
            exp = {2'(m_st[i]), 5'(exp_pos(i)), 1'(m_up[i]), 4'(m_run[i]),
                   1'(m_end[i]), (m_st[i] == 3), (m_st[i] == 1 || m_st[i] == 2)};
            n_assert++;
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL model[%0d] st/ptn/updn/run/end/done/busy observed=%h expected=%h",
                       i, obs, exp);
            end
        end
    endtask

    task automatic check_val(string tag, int obs, int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            for (int i = 0; i < c_N; i++) model_step(i);
            #1;
            check_all();
        end
    endtask

    task automatic tick_pulses(int n, int gap);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1; cyc(1);
            tick = 1'b0; cyc(gap);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start = 1'b0; pause = 1'b0; mode = 1'b0; dir_in = 1'b1;
        for (int i = 0; i < c_N; i++) begin
            m_st[i] = 0; m_t[i] = 0; m_up[i] = 1; m_run[i] = 0; m_end[i] = 0;
        end
        do_reset();
        check_val("reset_state", st[0], 0);
        check_val("reset_updn", updn[0], 1);

        // Wrap mode, up, ticks every 4 clocks through the whole game.
        start = 1'b1; dir_in = 1'b1; mode = 1'b0; cyc(1); start = 1'b0;
        tick_pulses(19, 3);
        check_val("t1_ptn19", ptn[0], 19);
        tick_pulses(1, 0);
        check_val("t1_wrap_ptn", ptn[0], 0);
        check_val("t1_run2", run[0], 2);
        check_val("t1_run_end", rend[0], 1);
        cyc(1);
        check_val("t1_run_end_drop", rend[0], 0);
        tick_pulses(160, 3);
        check_val("t1_done", dn[0], 1);
        check_val("t1_run9", run[0], 9);
        check_val("t1_ptn_end", ptn[0], 19);

        // Restart from DONE downwards.
        start = 1'b1; dir_in = 1'b0; cyc(1); start = 1'b0;
        check_val("t4_ptn", ptn[0], 19);
        check_val("t4_busy", bsy[0], 1);
        check_val("t4_run1", run[0], 1);

        // Ping-pong from down on the short instance.
        do_reset();
        start = 1'b1; dir_in = 1'b0; mode = 1'b1; cyc(1); start = 1'b0;
        tick_pulses(4, 1);
        check_val("t2_dwell_ptn", ptn[1], 0);
        check_val("t2_dwell_updn", updn[1], 1);
        tick_pulses(8, 1);
        check_val("t2_done", st[1], 3);
        check_val("t2_done_ptn", ptn[1], 0);

        // Pause with coincident tick, held pause, resume.
        do_reset();
        start = 1'b1; dir_in = 1'b1; mode = 1'b0; cyc(1); start = 1'b0;
        tick_pulses(7, 1);
        pause = 1'b1; tick = 1'b1; cyc(1); tick = 1'b0; pause = 1'b0;
        tick_pulses(10, 1);
        check_val("t3_hold", ptn[0], 7);
        start = 1'b1; pause = 1'b1; cyc(2);
        check_val("t3_pause_wins", st[0], 2);
        pause = 1'b0; cyc(1); start = 1'b0;
        tick_pulses(1, 1);
        check_val("t3_resume", ptn[0], 8);

        // Reset in the middle of run 5.
        do_reset();
        start = 1'b1; dir_in = 1'b1; mode = 1'b0; cyc(1); start = 1'b0;
        tick_pulses(92, 0);
        check_val("t5_run5", run[0], 5);
        check_val("t5_ptn12", ptn[0], 12);
        rst = 1'b1; tick = 1'b1; cyc(1); rst = 1'b0; tick = 1'b0;
        check_val("t5_rst_ptn", ptn[0], 0);
        check_val("t5_rst_busy", bsy[0], 0);

        // Continuous tick with start held into RUN.
        do_reset();
        dir_in = 1'b1; start = 1'b1; tick = 1'b1; cyc(3); start = 1'b0;
        check_val("t6_done", st[2], 3);
        check_val("t6_run_end", rend[2], 1);
        cyc(1); tick = 1'b0;
        check_val("t6_run_end_once", rend[2], 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            rst    = ($urandom_range(0, 299) == 0);
            tick   = ($urandom_range(0, 1) == 1);
            start  = ($urandom_range(0, 7) == 0);
            pause  = ($urandom_range(0, 11) == 0);
            dir_in = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            cyc(1);
        end
        rst = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snake_run_ctrl.md
Name: snake_run_ctrl

Overview:
Sequencer for the snake LED display. It generates the pattern counter (0..CNT_LENGTH-1), the count direction, and the run index from a slow tick enable. It also handles start, pause and resume, and asserts a done status after MAX_RUNS runs. It sits between the clock-divider tick and the pattern decoder / seven-segment run display.

Parameters:
CNT_LENGTH  20  pattern positions per run, 2..31; ptn_cnt spans 0..CNT_LENGTH-1
MAX_RUNS    9   runs per game, 1..15; run_cnt spans 1..MAX_RUNS

Ports:
clk       input   1  system clock; all logic on posedge clk
rst       input   1  synchronous, active-high reset
tick      input   1  one-cycle step enable from the clock divider
start     input   1  level; start from IDLE/DONE, resume from PAUSE
pause     input   1  level; pause from RUN
mode      input   1  0 = wrap (same direction every run), 1 = ping-pong (direction flips each run)
dir_in    input   1  initial direction sampled on start: 1 = up, 0 = down
ptn_cnt   output  5  current pattern position
updn      output  1  current direction: 1 = up, 0 = down
run_cnt   output  4  current run index
run_end   output  1  one-cycle pulse when a run completes
done      output  1  high in DONE
busy      output  1  high in RUN or PAUSE
state     output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (rst=1 at posedge) wins over everything and produces:
  - state=IDLE, ptn_cnt=0, updn=1, run_cnt=0, run_end=0, done=0, busy=0.
- All outputs are registered. start, pause and tick are sampled at the same edge.
- Definitions:
  - LAST = CNT_LENGTH-1.
  - at_end = (updn=1 and ptn_cnt==LAST) or (updn=0 and ptn_cnt==0).
- IDLE:
  - start=1: updn<=dir_in, ptn_cnt<=(dir_in ? 0 : LAST), run_cnt<=1, go to RUN.
  - pause and tick are ignored.
- RUN, evaluated in priority order:
  1. pause=1: go to PAUSE. A tick in the same cycle is ignored and nothing changes.
  2. tick=1 and not at_end: ptn_cnt steps by ±1 per updn.
  3. tick=1 and at_end and run_cnt==MAX_RUNS: go to DONE, run_end<=1, ptn_cnt/updn/run_cnt hold.
  4. tick=1 and at_end and run_cnt<MAX_RUNS: run_cnt<=run_cnt+1, run_end<=1, then:
     - mode=0: ptn_cnt reloads to the start point for the unchanged updn (up → 0, down → LAST).
     - mode=1: updn toggles and ptn_cnt holds at the endpoint (one-tick dwell). The next tick steps away from it.
  - start is ignored in RUN.
- PAUSE:
  - ptn_cnt, updn and run_cnt hold. tick is ignored.
  - start=1 goes to RUN. If pause is also high, pause wins and the block stays in PAUSE.
- DONE:
  - done=1; all counters hold.
  - start=1 restarts exactly as from IDLE (dir_in resampled, run_cnt<=1).
- Output rules:
  - run_end is high for exactly one cycle after the completing tick; 0 otherwise.
  - busy = (state==RUN or PAUSE). done = (state==DONE).
- Width rules:
  - ptn_cnt never leaves 0..LAST; there is no arithmetic wrap past 0 or 31.
  - run_cnt never exceeds MAX_RUNS.
  - Comparisons use 5-bit and 4-bit truncated parameter values.
- Tick stream: back-to-back ticks (tick held high) step once per clock.
- Reset mid-operation: the next edge yields reset values regardless of state.

Test Plan:
1. Reset, then start=1, dir_in=1, mode=0, tick pulsed every 4 clocks → ptn_cnt 0,1,…,19; on the 20th tick ptn_cnt=0, run_cnt=2, run_end one pulse; after 180 ticks state=DONE, done=1, run_cnt=9, ptn_cnt=19.
2. start with dir_in=0, mode=1, CNT_LENGTH=4, MAX_RUNS=3 → ptn_cnt 3,2,1,0, then 0 (dwell, updn=1, run_cnt=2), then 1,2,3, then 3 (updn=0, run_cnt=3), then 2,1,0, then DONE with ptn_cnt=0.
3. In RUN at ptn_cnt=7, assert pause with tick in the same cycle → state=PAUSE, ptn_cnt stays 7 through 10 ticks; start=1 with pause=1 → stays PAUSE; start=1 with pause=0 → RUN, next tick gives ptn_cnt=8.
4. In DONE, start=1 with dir_in=0 → state=RUN, run_cnt=1, ptn_cnt=19, updn=0, done=0, busy=1.
5. Assert rst while in RUN at run_cnt=5, ptn_cnt=12 with tick high → next edge: state=0, ptn_cnt=0, updn=1, run_cnt=0, run_end=0, busy=0.
6. Hold tick=1 continuously with MAX_RUNS=1, CNT_LENGTH=2, dir_in=1 → ptn_cnt 0,1, then DONE on the 2nd tick-clock, run_end high exactly one cycle, start ignored while in RUN.
